// File: rtl/fpu_issue_queue.sv
// Request FIFO feeding a fixed-latency FPU; issues one op per cycle and tags results via a latency-matched pipe.
// Issue is no earlier than one cycle after push; results appear FPU_LATENCY+1 cycles after the issue edge; InReady drops when full.
module fpu_issue_queue #(
   parameter int DEPTH       = 8,
   parameter int FPU_LATENCY = 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    InValid,
   output logic                    InReady,
   input  logic [31:0]             InOperand1,
   input  logic [31:0]             InOperand2,
   input  logic [1:0]              InOperation,
   input  logic                    IssueEn,
   output logic [31:0]             FpuOperand1,
   output logic [31:0]             FpuOperand2,
   output logic [1:0]              FpuOperation,
   input  logic [31:0]             FpuResult,
   output logic                    OutValid,
   output logic [31:0]             OutResult,
   output logic [1:0]              OutOperation,
   output logic [7:0]              OutTag,
   output logic [$clog2(DEPTH):0]  Count
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;

   typedef struct packed {
      logic       vld;
      logic [7:0] tag;
      logic [1:0] op;
   } pipe_t;

   req_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    tag_q, tag_d;
   req_t          fpu_q, fpu_d;
   pipe_t         pipe_q [FPU_LATENCY+1];
   pipe_t         pipe_in;
   req_t          head;
   logic          push;
   logic          issue;

   assign InReady = !RST && (count_q < (AW+1)'(DEPTH));
   assign push    = InValid && InReady;
   assign issue   = IssueEn && (count_q != '0);
   assign head    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      tag_d       = tag_q;
      fpu_d       = fpu_q;
      pipe_in     = '0;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (issue) begin
         rd_ptr_d    = rd_ptr_q + 1'b1;
         tag_d       = tag_q + 8'd1;
         fpu_d       = head;
         pipe_in.vld = 1'b1;
         pipe_in.tag = tag_q;
         pipe_in.op  = head.op;
      end
      // Simultaneous push and issue leave the occupancy unchanged.
      if (push && !issue) begin
         count_d = count_q + 1'b1;
      end else if (issue && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{op: InOperation, a: InOperand1, b: InOperand2};
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         tag_q    <= '0;
         fpu_q    <= '0;
         for (int i = 0; i <= FPU_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         tag_q     <= tag_d;
         fpu_q     <= fpu_d;
         pipe_q[0] <= pipe_in;
         for (int i = 1; i <= FPU_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign FpuOperand1  = fpu_q.a;
   assign FpuOperand2  = fpu_q.b;
   assign FpuOperation = fpu_q.op;
   assign OutValid     = pipe_q[FPU_LATENCY].vld;
   assign OutTag       = pipe_q[FPU_LATENCY].tag;
   assign OutOperation = pipe_q[FPU_LATENCY].op;
   assign OutResult    = FpuResult;
   assign Count        = count_q;

endmodule

// File: doc/fpu_issue_queue.md
Name: fpu_issue_queue

Overview:
- Upstream feeder for the FPU. Buffers {Operation, Operand1, Operand2} requests in a FIFO and issues at most one per cycle to the FPU operand inputs.
- Tracks in-flight operations through a latency-matched shift register. Presents each FPU Result with a valid strobe, the originating operation code and a sequence tag.
- Replaces free-running stimulus with a handshaked, result-aligned interface for the FPU and its downstream consumers.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
FPU_LATENCY, 1, CLK cycles from FPU operand inputs changing to the matching FpuResult (>=1)

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous active-high reset
InValid  input  1  request present
InReady  output  1  queue can accept a request
InOperand1  input  32  IEEE-754 single operand 1
InOperand2  input  32  IEEE-754 single operand 2
InOperation  input  2  FPU operation code, passed through unchanged
IssueEn  input  1  issue permitted this cycle
FpuOperand1  output  32  to FPU Operand1 (registered)
FpuOperand2  output  32  to FPU Operand2 (registered)
FpuOperation  output  2  to FPU Operation (registered)
FpuResult  input  32  from FPU Result
OutValid  output  1  OutResult valid this cycle
OutResult  output  32  FpuResult, forwarded combinationally
OutOperation  output  2  operation code of the result shown
OutTag  output  8  issue sequence number of the result shown
Count  output  log2(DEPTH)+1  entries currently queued

Behaviour:
- Reset (sampled on the CLK edge with RST=1):
  - read/write pointers, Count, tag counter, latency pipe -> 0
  - FpuOperand1/2 -> 0, FpuOperation -> 0
  - OutValid=0, OutTag=0, OutOperation=0
  - InReady=0 while RST=1
  - In-flight operations are discarded; no OutValid for them after reset.
- Push occurs when InValid && InReady on an edge. The entry is written at the write pointer and the pointer increments modulo DEPTH.
- InReady = !RST && (Count < DEPTH). It depends on the current Count only. When full, a same-cycle pop does not enable a push.
- Issue occurs when IssueEn && Count>0:
  - head entry loads into FpuOperand1/2 and FpuOperation on the edge
  - read pointer increments modulo DEPTH
  - tag counter increments; 255 wraps to 0
- No issue: Fpu* registers hold their last value, so FPU inputs stay stable.
- Count: +1 on push only, -1 on issue only, unchanged when both or neither occur. It never exceeds DEPTH and never underflows.
- Empty queue: there is no bypass. A request pushed in cycle N is issued no earlier than the edge ending cycle N+1.
- Latency pipe: a FPU_LATENCY+1 stage shift register of {valid, tag, operation}. It is loaded at each issue edge; stage 0 is cleared when there is no issue.
- OutValid, OutTag and OutOperation come from the last stage. An op issued at the edge ending cycle N has Fpu* visible in N+1 and OutValid=1 in cycle N+1+FPU_LATENCY. OutResult=FpuResult in that cycle.
- Back-to-back issues produce back-to-back OutValid pulses in issue order with consecutive tags.
- OutResult always mirrors FpuResult; it is meaningful only when OutValid=1.
- RST mid-operation: queued and in-flight entries are lost, and the tag restarts at 0.

Test Plan:
1. Reset then single op: push {op=2'b10, 0x3F800000, 0x40000000} with IssueEn=1.
   -> FpuOperand1=0x3F800000 two cycles after the push edge. OutValid=1 with OutTag=0 and OutOperation=2'b10 exactly FPU_LATENCY cycles later. OutResult equals FpuResult.
2. Fill: IssueEn=0, push 9 requests.
   -> 8 accepted, Count=8, InReady=0, 9th held. Set IssueEn=1 -> 8 results, tags 0..7 in push order, 9th then accepted.
3. Simultaneous push and issue at Count=3 -> Count stays 3 and ordering is preserved.
   Same attempt at Count=8 -> push refused, Count becomes 7.
4. Tag wrap: issue 257 ops -> OutTag sequence ...254, 255, 0 on the 257th result.
5. IssueEn gating: queue 2 entries and toggle IssueEn 1,0,1.
   -> Fpu* holds the first operands during the gap, and OutValid pulses are separated by one cycle.
6. Reset mid-flight: 3 issued and 2 queued, assert RST for 1 cycle.
   -> no OutValid afterwards, Count=0, Fpu*=0, and the next issued op carries OutTag=0.
